// File: rtl/usb_uart_fifo_bridge_ep_if.sv
// Endpoint-side and client-side signal bundle for the USB/UART FIFO bridge.
// The bridge takes the slave view; the arbiter/client environment takes the master view.
interface usb_uart_fifo_bridge_ep_if #(
  parameter int IN_AW  = 4,
  parameter int OUT_AW = 4
);
  logic              out_ep_req;
  logic              out_ep_grant;
  logic              out_ep_data_avail;
  logic              out_ep_setup;
  logic              out_ep_data_get;
  logic [7:0]        out_ep_data;
  logic              out_ep_stall;
  logic              out_ep_acked;
  logic              in_ep_req;
  logic              in_ep_grant;
  logic              in_ep_data_free;
  logic              in_ep_data_put;
  logic [7:0]        in_ep_data;
  logic              in_ep_data_done;
  logic              in_ep_stall;
  logic              in_ep_acked;
  logic              uart_we;
  logic [7:0]        uart_di;
  logic              uart_wait;
  logic              uart_re;
  logic [7:0]        uart_do;
  logic              uart_ready;
  logic [IN_AW:0]    in_level;
  logic [OUT_AW:0]   out_level;

  modport slave (
    output out_ep_req, out_ep_data_get, out_ep_stall,
    input  out_ep_grant, out_ep_data_avail, out_ep_setup, out_ep_data, out_ep_acked,
    output in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
    input  in_ep_grant, in_ep_data_free, in_ep_acked,
    input  uart_we, uart_di, uart_re,
    output uart_wait, uart_do, uart_ready, in_level, out_level
  );

  modport master (
    input  out_ep_req, out_ep_data_get, out_ep_stall,
    output out_ep_grant, out_ep_data_avail, out_ep_setup, out_ep_data, out_ep_acked,
    input  in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
    output in_ep_grant, in_ep_data_free, in_ep_acked,
    output uart_we, uart_di, uart_re,
    input  uart_wait, uart_do, uart_ready, in_level, out_level
  );
endinterface

// File: rtl/usb_uart_fifo_bridge_ep.sv
// Bidirectional bridge: client bytes are packed into bulk IN packets (flushed on idle),
// bulk OUT bytes are buffered for the client. The two directions are independent.
module usb_uart_fifo_bridge_ep #(
  parameter int IN_AW        = 4,
  parameter int OUT_AW       = 4,
  parameter int MAX_PKT      = 8,
  parameter int FLUSH_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  usb_uart_fifo_bridge_ep_if.slave      bus
);

  localparam int IN_DEPTH  = 1 << IN_AW;
  localparam int OUT_DEPTH = 1 << OUT_AW;
  localparam int TW        = $clog2(FLUSH_CYCLES + 1);

  localparam logic [IN_AW:0]    IN_FULL  = (IN_AW+1)'(IN_DEPTH);
  localparam logic [IN_AW:0]    IN_ONE   = (IN_AW+1)'(1);
  localparam logic [IN_AW:0]    PKT_MAX  = (IN_AW+1)'(MAX_PKT);
  localparam logic [IN_AW:0]    PKT_LAST = (IN_AW+1)'(MAX_PKT - 1);
  localparam logic [OUT_AW:0]   OUT_FULL = (OUT_AW+1)'(OUT_DEPTH);
  localparam logic [OUT_AW:0]   OUT_ONE  = (OUT_AW+1)'(1);
  localparam logic [TW-1:0]     FLUSH_T  = TW'(FLUSH_CYCLES);

  typedef enum logic [1:0] {IN_IDLE, IN_REQ, IN_SEND, IN_DONE} in_state_e;
  typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_READ} out_state_e;

  // ---------------- IN FIFO (client -> host) ----------------
  logic [7:0]        in_mem_q [IN_DEPTH];
  logic [IN_AW-1:0]  in_wp_q, in_wp_d, in_rp_q, in_rp_d;
  logic [IN_AW:0]    in_cnt_q, in_cnt_d;
  logic              in_push, in_pop;

  in_state_e         in_state_q, in_state_d;
  logic [IN_AW:0]    bcnt_q, bcnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              in_put, in_req, in_done;

  assign in_push = bus.uart_we && (in_cnt_q != IN_FULL);
  assign in_pop  = in_put;

  always_ff @(posedge clk) begin
    if (in_push) in_mem_q[in_wp_q] <= bus.uart_di;
  end

  always_comb begin
    in_wp_d  = in_push ? in_wp_q + IN_AW'(1) : in_wp_q;
    in_rp_d  = in_pop  ? in_rp_q + IN_AW'(1) : in_rp_q;
    in_cnt_d = in_cnt_q;
    if (in_push && !in_pop)      in_cnt_d = in_cnt_q + IN_ONE;
    else if (!in_push && in_pop) in_cnt_d = in_cnt_q - IN_ONE;
  end

  // Idle timer only runs while a partial packet sits untouched in IDLE
  always_comb begin
    timer_d = timer_q;
    if (in_push || (in_cnt_q == '0) || (in_state_q != IN_IDLE)) timer_d = '0;
    else if (timer_q != FLUSH_T)                               timer_d = timer_q + TW'(1);
  end

  always_comb begin
    in_state_d = in_state_q;
    bcnt_d     = bcnt_q;
    in_put     = 1'b0;
    in_req     = 1'b0;
    in_done    = 1'b0;
    case (in_state_q)
      IN_IDLE: begin
        bcnt_d = '0;
        if ((in_cnt_q >= PKT_MAX) || ((in_cnt_q != '0) && (timer_q == FLUSH_T)))
          in_state_d = IN_REQ;
      end
      IN_REQ: begin
        in_req = 1'b1;
        if (bus.in_ep_grant && bus.in_ep_data_free) in_state_d = IN_SEND;
      end
      IN_SEND: begin
        in_req = 1'b1;
        if (bus.in_ep_data_free && (in_cnt_q != '0)) begin
          in_put = 1'b1;
          bcnt_d = bcnt_q + IN_ONE;
          if (bcnt_q == PKT_LAST) in_state_d = IN_DONE;
        end else if ((in_cnt_q == '0) && (bcnt_q != '0)) begin
          in_state_d = IN_DONE;
        end
      end
      IN_DONE: begin
        in_done    = 1'b1;
        in_state_d = IN_IDLE;
      end
      default: in_state_d = IN_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_wp_q    <= '0;
      in_rp_q    <= '0;
      in_cnt_q   <= '0;
      in_state_q <= IN_IDLE;
      bcnt_q     <= '0;
      timer_q    <= '0;
    end else begin
      in_wp_q    <= in_wp_d;
      in_rp_q    <= in_rp_d;
      in_cnt_q   <= in_cnt_d;
      in_state_q <= in_state_d;
      bcnt_q     <= bcnt_d;
      timer_q    <= timer_d;
    end
  end

  assign bus.in_ep_req       = in_req;
  assign bus.in_ep_data_put  = in_put;
  assign bus.in_ep_data_done = in_done;
  assign bus.in_ep_data      = (in_cnt_q != '0) ? in_mem_q[in_rp_q] : 8'h00;
  assign bus.in_ep_stall     = 1'b0;
  assign bus.uart_wait       = (in_cnt_q == IN_FULL);
  assign bus.in_level        = in_cnt_q;

  // ---------------- OUT FIFO (host -> client) ----------------
  logic [7:0]        out_mem_q [OUT_DEPTH];
  logic [OUT_AW-1:0] out_wp_q, out_wp_d, out_rp_q, out_rp_d;
  logic [OUT_AW:0]   out_cnt_q, out_cnt_d, out_free;
  logic              out_push, out_pop;

  out_state_e        out_state_q, out_state_d;
  logic              inflight_q, inflight_d;
  logic              out_get, out_req;

  // A byte fetched last cycle always has a reserved slot, so the push never overflows
  assign out_push = inflight_q;
  assign out_pop  = bus.uart_re && (out_cnt_q != '0);
  assign out_free = OUT_FULL - out_cnt_q;

  always_ff @(posedge clk) begin
    if (out_push) out_mem_q[out_wp_q] <= bus.out_ep_data;
  end

  always_comb begin
    out_wp_d  = out_push ? out_wp_q + OUT_AW'(1) : out_wp_q;
    out_rp_d  = out_pop  ? out_rp_q + OUT_AW'(1) : out_rp_q;
    out_cnt_d = out_cnt_q;
    if (out_push && !out_pop)      out_cnt_d = out_cnt_q + OUT_ONE;
    else if (!out_push && out_pop) out_cnt_d = out_cnt_q - OUT_ONE;
  end

  always_comb begin
    out_state_d = out_state_q;
    out_get     = 1'b0;
    out_req     = 1'b0;
    case (out_state_q)
      OUT_IDLE: begin
        if (bus.out_ep_data_avail) out_state_d = OUT_REQ;
      end
      OUT_REQ: begin
        out_req = 1'b1;
        if (bus.out_ep_grant) out_state_d = OUT_READ;
      end
      OUT_READ: begin
        out_req = 1'b1;
        if (bus.out_ep_data_avail && (out_free > {{OUT_AW{1'b0}}, inflight_q}))
          out_get = 1'b1;
        else if (!bus.out_ep_data_avail && !inflight_q)
          out_state_d = OUT_IDLE;
      end
      default: out_state_d = OUT_IDLE;
    endcase
    inflight_d = out_get;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_wp_q    <= '0;
      out_rp_q    <= '0;
      out_cnt_q   <= '0;
      out_state_q <= OUT_IDLE;
      inflight_q  <= 1'b0;
    end else begin
      out_wp_q    <= out_wp_d;
      out_rp_q    <= out_rp_d;
      out_cnt_q   <= out_cnt_d;
      out_state_q <= out_state_d;
      inflight_q  <= inflight_d;
    end
  end

  assign bus.out_ep_req      = out_req;
  assign bus.out_ep_data_get = out_get;
  assign bus.out_ep_stall    = 1'b0;
  assign bus.uart_ready      = (out_cnt_q != '0);
  assign bus.uart_do         = (out_cnt_q != '0) ? out_mem_q[out_rp_q] : 8'h00;
  assign bus.out_level       = out_cnt_q;

  logic unused_inputs;
  assign unused_inputs = ^{bus.out_ep_setup, bus.out_ep_acked, bus.in_ep_acked};

endmodule

// File: doc/usb_uart_fifo_bridge_ep.md
Name: usb_uart_fifo_bridge_ep

Overview:
Bidirectional, parametrised bridge between a byte-wide UART-style client port and one USB bulk OUT/IN endpoint pair. A host-to-device FIFO buffers OUT-endpoint bytes for the client. A device-to-host FIFO packs client bytes into IN packets of up to MAX_PKT bytes. A short packet is flushed after an idle timeout. Sits between the USB endpoint arbiter and the CPU/UART-facing logic, replacing the single-byte, IN-only bridge endpoint.

Parameters:
IN_AW, 4, log2 of IN FIFO depth (device-to-host); depth = 2**IN_AW bytes
OUT_AW, 4, log2 of OUT FIFO depth (host-to-device); depth = 2**OUT_AW bytes
MAX_PKT, 8, maximum bytes per IN packet; 1..2**IN_AW
FLUSH_CYCLES, 1024, idle clocks before a partial IN packet is sent; >=1

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
out_ep_req  out  1  request OUT endpoint buffer access
out_ep_grant  in  1  OUT access granted
out_ep_data_avail  in  1  OUT buffer holds unread bytes
out_ep_setup  in  1  current OUT packet is SETUP (ignored)
out_ep_data_get  out  1  read strobe; byte valid on out_ep_data next cycle
out_ep_data  in  8  OUT byte
out_ep_stall  out  1  tied 0
out_ep_acked  in  1  unused
in_ep_req  out  1  request IN endpoint buffer access
in_ep_grant  in  1  IN access granted
in_ep_data_free  in  1  IN buffer can accept a byte
in_ep_data_put  out  1  write strobe for in_ep_data
in_ep_data  out  8  IN byte (IN FIFO head)
in_ep_data_done  out  1  one-cycle end-of-packet pulse
in_ep_stall  out  1  tied 0
in_ep_acked  in  1  unused
uart_we  in  1  client write strobe
uart_di  in  8  client write data
uart_wait  out  1  IN FIFO full; writes ignored
uart_re  in  1  client read strobe (pop)
uart_do  out  8  OUT FIFO head
uart_ready  out  1  OUT FIFO non-empty
in_level  out  IN_AW+1  IN FIFO occupancy
out_level  out  OUT_AW+1  OUT FIFO occupancy

Behaviour:
- Reset (reset=0, async): FIFOs empty, both FSMs IDLE, timer 0; all outputs 0. Any packet in progress is abandoned: no done pulse is issued and in_ep_req drops immediately.
- FIFOs: circular buffers with pointer wrap and count registers.
  - Push is accepted only if count < depth at the cycle start. Pop is accepted only if count > 0.
  - Push and pop in the same cycle leave count unchanged.
  - uart_wait = (in_level == 2**IN_AW). uart_we while uart_wait is dropped silently.
  - uart_re while !uart_ready is ignored. uart_do is valid whenever uart_ready=1.
- IN FSM (IDLE, REQ, SEND, DONE):
  - IDLE -> REQ when in_level >= MAX_PKT, or when in_level > 0 and the timer has reached FLUSH_CYCLES.
  - The timer clears on any accepted uart_we, while in_level == 0, and outside IDLE. Otherwise it increments, saturating at FLUSH_CYCLES.
  - REQ: in_ep_req=1. Go to SEND when in_ep_grant && in_ep_data_free.
  - SEND: each cycle with in_ep_data_free && in_level>0, assert in_ep_data_put, pop the IN FIFO and increment the byte count. in_ep_data is the FIFO head, combinational.
  - If in_ep_data_free falls, hold without a put.
  - Go to DONE after the put of byte MAX_PKT, or on a cycle where in_level==0 after at least one put.
  - DONE: in_ep_data_done=1 for exactly one cycle, in_ep_req=0, then IDLE.
  - Client pushes during SEND are allowed. They join the current packet only up to the MAX_PKT limit.
- OUT FSM (IDLE, REQ, READ):
  - IDLE -> REQ when out_ep_data_avail.
  - REQ: out_ep_req=1. Go to READ on out_ep_grant.
  - READ: assert out_ep_data_get when out_ep_data_avail and free slots exceed bytes in flight, so at most one byte is outstanding. The OUT FIFO never overflows.
  - The byte is pushed on the cycle after its get.
  - READ -> IDLE (out_ep_req=0) when out_ep_data_avail=0 and no byte is in flight.
  - If the FIFO is full, hold out_ep_req, stall gets, and resume as the client pops.
- out_ep_setup, out_ep_acked and in_ep_acked are ignored.
- The two paths are fully independent and may be active in the same cycle.

Test Plan:
- Write 8 bytes 0x41..0x48 back-to-back with in_ep_free/grant=1 -> one packet: 8 puts carrying 0x41..0x48 in order, then one done pulse, then in_ep_req=0.
- Write 3 bytes then idle -> no req before FLUSH_CYCLES. After the timeout, a 3-put packet and done are sent; in_level returns to 0.
- Write 17 bytes with grant held low -> after 16, uart_wait=1 and the 17th byte is dropped. Then grant -> packets of 8 and 8 with data in order.
- Drop in_ep_data_free for 5 cycles mid-packet -> no put during the gap. The packet completes with the correct 8 bytes and a single done.
- OUT path: supply 20 bytes with uart_re held low -> gets stall at 16 bytes with out_level=16. Pop 4 -> remaining 4 bytes read; uart_do sequence matches the source.
- Assert reset during IN SEND after 3 puts -> all outputs 0 immediately, no done, both levels 0. The next write starts a fresh packet.
